// File: rtl/fetch_queue_unit_if.sv
// Bundle of the fetch stage's memory, decode and redirect signals.
// Handshakes: a transfer happens on a rising edge where valid & ready are both high; valid never waits on ready.
interface fetch_queue_unit_if #(
   parameter int DATA_W = 32
);
   logic              redirect_valid;
   logic [DATA_W-1:0] redirect_pc;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [DATA_W-1:0] mem_pc;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_inst;
   logic              inst_valid;
   logic              inst_ready;
   logic [DATA_W-1:0] inst;
   logic [DATA_W-1:0] pc_out;
   logic [DATA_W-1:0] pc_next;
   logic              busy;

   modport master (
      input  redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_inst, inst_ready,
      output mem_req_valid, mem_pc, inst_valid, inst, pc_out, pc_next, busy
   );

   modport slave (
      output redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_inst, inst_ready,
      input  mem_req_valid, mem_pc, inst_valid, inst, pc_out, pc_next, busy
   );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: PC register, credit-limited fetch requests, in-order response queue
// toward decode, and redirect handling that discards responses still in flight.
module fetch_queue_unit #(
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [DATA_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = 4
) (
   input logic               clk,
   input logic               rstn,
   fetch_queue_unit_if.master bus
);
   localparam int                PW      = $clog2(DEPTH);
   localparam int                CW      = PW + 1;
   localparam logic [DATA_W-1:0] STEP    = DATA_W'(PC_STEP);
   localparam logic [CW:0]       LIMIT   = (CW+1)'(DEPTH);

   logic [DATA_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] tag_mem_q [DEPTH];
   logic [PW-1:0]     tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
   logic [DATA_W-1:0] iq_inst_q [DEPTH];
   logic [DATA_W-1:0] iq_pc_q   [DEPTH];
   logic [PW-1:0]     iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;
   logic [CW-1:0]     count_q, count_d, out_q, out_d, drop_q, drop_d;

   logic              redirect, req_fire, resp_ok, push, pop, head_valid;
   logic [CW:0]       credit_used;

   // Queued entries plus in-flight requests may never exceed DEPTH, so a response always has a slot.
   assign redirect    = bus.redirect_valid;
   assign credit_used = {1'b0, count_q} + {1'b0, out_q};
   assign bus.mem_req_valid = rstn & ~redirect & (credit_used < LIMIT);
   assign bus.mem_pc  = pc_q;
   assign req_fire    = bus.mem_req_valid & bus.mem_req_ready;
   assign resp_ok     = bus.mem_resp_valid & (out_q != '0);
   assign push        = resp_ok & (drop_q == '0) & ~redirect;
   assign head_valid  = (count_q != '0);
   assign pop         = head_valid & bus.inst_ready;

   always_comb begin
      pc_d     = pc_q;
      tag_wr_d = tag_wr_q;
      tag_rd_d = tag_rd_q;
      iq_wr_d  = iq_wr_q;
      iq_rd_d  = iq_rd_q;
      count_d  = count_q;
      drop_d   = drop_q;
      out_d    = out_q + CW'(req_fire) - CW'(resp_ok);
      if (req_fire) begin
         pc_d     = pc_q + STEP;
         tag_wr_d = tag_wr_q + PW'(1);
      end
      if (resp_ok) tag_rd_d = tag_rd_q + PW'(1);
      if (redirect) begin
         // Every request still in flight now belongs to the abandoned path.
         pc_d    = bus.redirect_pc;
         count_d = '0;
         iq_wr_d = '0;
         iq_rd_d = '0;
         drop_d  = out_q - CW'(resp_ok);
      end else begin
         if (resp_ok && drop_q != '0) drop_d = drop_q - CW'(1);
         if (push) iq_wr_d = iq_wr_q + PW'(1);
         if (pop)  iq_rd_d = iq_rd_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         pc_q     <= RESET_PC;
         tag_wr_q <= '0;
         tag_rd_q <= '0;
         iq_wr_q  <= '0;
         iq_rd_q  <= '0;
         count_q  <= '0;
         out_q    <= '0;
         drop_q   <= '0;
      end else begin
         pc_q     <= pc_d;
         tag_wr_q <= tag_wr_d;
         tag_rd_q <= tag_rd_d;
         iq_wr_q  <= iq_wr_d;
         iq_rd_q  <= iq_rd_d;
         count_q  <= count_d;
         out_q    <= out_d;
         drop_q   <= drop_d;
      end
   end

   // Storage needs no reset: occupancy counters decide what is visible.
   always_ff @(posedge clk) begin
      if (req_fire) tag_mem_q[tag_wr_q] <= pc_q;
      if (push) begin
         iq_inst_q[iq_wr_q] <= bus.mem_inst;
         iq_pc_q[iq_wr_q]   <= tag_mem_q[tag_rd_q];
      end
   end

   assign bus.inst_valid = head_valid;
   assign bus.inst       = head_valid ? iq_inst_q[iq_rd_q] : '0;
   assign bus.pc_out     = head_valid ? iq_pc_q[iq_rd_q]   : '0;
   assign bus.pc_next    = bus.pc_out + STEP;
   assign bus.busy       = (out_q != '0) | head_valid;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: a latency-programmable memory responder feeds the main
// instance; a second instance starting near the top of the address space exercises PC wrap.
module tb_fetch_queue_unit;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rstn;
   logic rstn_b;
   always #5 clk = ~clk;

   fetch_queue_unit_if #(.DATA_W(DW)) fq ();
   fetch_queue_unit_if #(.DATA_W(DW)) fq_b ();

   fetch_queue_unit #(.DATA_W(DW), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) u_dut (
      .clk(clk), .rstn(rstn), .bus(fq)
   );
   fetch_queue_unit #(.DATA_W(DW), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) u_dut_b (
      .clk(clk), .rstn(rstn_b), .bus(fq_b)
   );

   int total = 0;
   int bad   = 0;
   logic [DW-1:0] exp_pc;
   logic [DW-1:0] pb;
   int n_acc;

   function automatic logic [DW-1:0] mem_word(input logic [DW-1:0] pc);
      return pc ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory model: answers accepted requests in order, lat cycles after acceptance.
   typedef struct {
      int            due;
      logic [DW-1:0] pc;
   } pend_t;
   pend_t pend_q[$];
   int lat = 1;
   int rcyc = 0;
   logic acc_seen = 1'b0;
   logic [DW-1:0] acc_pc = '0;

   initial begin
      fq.mem_resp_valid = 1'b0;
      fq.mem_inst = '0;
      forever begin
         @(negedge clk);
         rcyc++;
         if (acc_seen) pend_q.push_back('{due: rcyc - 1 + lat, pc: acc_pc});
         if (pend_q.size() > 0 && pend_q[0].due <= rcyc) begin
            fq.mem_resp_valid = 1'b1;
            fq.mem_inst = mem_word(pend_q[0].pc);
            void'(pend_q.pop_front());
         end else begin
            fq.mem_resp_valid = 1'b0;
            fq.mem_inst = '0;
         end
         #3;
         acc_seen = fq.mem_req_valid & fq.mem_req_ready;
         acc_pc = fq.mem_pc;
      end
   end

   // Called at a falling edge; returns at a falling edge once nothing is in flight.
   task automatic wait_quiet();
      logic quiet = 1'b0;
      fq.mem_req_ready = 1'b0;
      fq.inst_ready = 1'b1;
      fq.redirect_valid = 1'b0;
      for (int i = 0; i < 40 && !quiet; i++) begin
         #1;
         quiet = (pend_q.size() == 0) && !fq.busy && !fq.mem_resp_valid;
         @(negedge clk);
      end
      chk("quiet_timeout", {31'b0, quiet}, 1);
   endtask

   // Called at a falling edge with inputs set; checks n delivered instructions from exp_pc on.
   task automatic drain_expect(input int n);
      int got = 0;
      for (int i = 0; i < 60 && got < n; i++) begin
         #1;
         if (fq.inst_valid && fq.inst_ready) begin
            chk("pc_out", fq.pc_out, exp_pc);
            chk("inst", fq.inst, mem_word(exp_pc));
            chk("pc_next", fq.pc_next, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            got++;
         end
         @(negedge clk);
      end
      chk("drain_count", got, n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      rstn_b = 1'b0;
      fq.redirect_valid = 1'b0;
      fq.redirect_pc = '0;
      fq.mem_req_ready = 1'b0;
      fq.inst_ready = 1'b0;
      fq_b.redirect_valid = 1'b0;
      fq_b.redirect_pc = '0;
      fq_b.mem_req_ready = 1'b0;
      fq_b.mem_resp_valid = 1'b0;
      fq_b.mem_inst = '0;
      fq_b.inst_ready = 1'b0;
      exp_pc = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_valid", fq.mem_req_valid, 0);
      chk("rst_inst_valid", fq.inst_valid, 0);
      chk("rst_inst", fq.inst, 0);
      chk("rst_pc_out", fq.pc_out, 0);
      chk("rst_busy", fq.busy, 0);
      @(negedge clk);

      // 1: streaming, latency 1
      rstn = 1'b1;
      fq.mem_req_ready = 1'b1;
      fq.inst_ready = 1'b1;
      #1;
      chk("t1_req_valid", fq.mem_req_valid, 1);
      chk("t1_mem_pc", fq.mem_pc, 32'h0);
      @(negedge clk);
      #1;
      chk("t1_valid_latency", fq.inst_valid, 0);
      chk("t1_mem_pc_next", fq.mem_pc, 32'h4);
      @(negedge clk);
      #1;
      chk("t1_first_valid", fq.inst_valid, 1);
      exp_pc = 32'h0;
      drain_expect(8);

      // 2: decode back-pressure fills the queue
      wait_quiet();
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      fq.inst_ready = 1'b0;
      fq.mem_req_ready = 1'b1;
      n_acc = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (fq.mem_req_valid && fq.mem_req_ready) n_acc++;
         @(negedge clk);
      end
      #1;
      chk("t2_accepts", n_acc, 4);
      chk("t2_req_blocked", fq.mem_req_valid, 0);
      chk("t2_head_valid", fq.inst_valid, 1);
      chk("t2_head_pc", fq.pc_out, 32'h0);
      chk("t2_head_inst", fq.inst, mem_word(32'h0));
      @(negedge clk);
      #1;
      chk("t2_head_stable", fq.pc_out, 32'h0);
      @(negedge clk);
      fq.inst_ready = 1'b1;
      exp_pc = 32'h0;
      drain_expect(5);

      // 3: redirect with three requests in flight (latency 5)
      wait_quiet();
      lat = 5;
      fq.mem_req_ready = 1'b1;
      fq.inst_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t3_req", fq.mem_req_valid, 1);
         @(negedge clk);
      end
      fq.redirect_valid = 1'b1;
      fq.redirect_pc = 32'h100;
      #1;
      chk("t3_no_req_on_redirect", fq.mem_req_valid, 0);
      chk("t3_busy", fq.busy, 1);
      @(negedge clk);
      fq.redirect_valid = 1'b0;
      #1;
      chk("t3_req_after", fq.mem_req_valid, 1);
      chk("t3_resume_pc", fq.mem_pc, 32'h100);
      exp_pc = 32'h100;
      drain_expect(2);

      // 4: redirect while the queue is full and decode pops in the same cycle
      wait_quiet();
      lat = 1;
      fq.inst_ready = 1'b0;
      fq.mem_req_ready = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      chk("t4_full_blocked", fq.mem_req_valid, 0);
      chk("t4_full_valid", fq.inst_valid, 1);
      @(negedge clk);
      fq.redirect_valid = 1'b1;
      fq.redirect_pc = 32'h200;
      fq.inst_ready = 1'b1;
      #1;
      chk("t4_pop_valid", fq.inst_valid, 1);
      @(negedge clk);
      fq.redirect_valid = 1'b0;
      #1;
      chk("t4_flushed", fq.inst_valid, 0);
      chk("t4_mem_pc", fq.mem_pc, 32'h200);
      exp_pc = 32'h200;
      drain_expect(2);

      // 6: reset with two requests in flight; their late responses must be ignored
      wait_quiet();
      lat = 6;
      fq.mem_req_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("t6_req", fq.mem_req_valid, 1);
         @(negedge clk);
      end
      fq.mem_req_ready = 1'b0;
      rstn = 1'b0;
      #1;
      chk("t6_rst_req_valid", fq.mem_req_valid, 0);
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("t6_idle_valid", fq.inst_valid, 0);
         chk("t6_idle_busy", fq.busy, 0);
         @(negedge clk);
      end
      lat = 1;
      fq.mem_req_ready = 1'b1;
      #1;
      chk("t6_restart_pc", fq.mem_pc, 32'h0);
      exp_pc = 32'h0;
      drain_expect(2);

      // 5: PC wrap on the second instance
      fq.mem_req_ready = 1'b0;
      rstn_b = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pb = 32'hFFFF_FFF8 + 32'(4 * i);
         fq_b.mem_req_ready = 1'b1;
         fq_b.mem_resp_valid = 1'b0;
         fq_b.inst_ready = 1'b1;
         #1;
         chk("t5_req_valid", fq_b.mem_req_valid, 1);
         chk("t5_mem_pc", fq_b.mem_pc, pb);
         @(negedge clk);
         fq_b.mem_req_ready = 1'b0;
         fq_b.mem_resp_valid = 1'b1;
         fq_b.mem_inst = mem_word(pb);
         #1;
         chk("t5_not_yet", fq_b.inst_valid, 0);
         @(negedge clk);
         fq_b.mem_resp_valid = 1'b0;
         #1;
         chk("t5_valid", fq_b.inst_valid, 1);
         chk("t5_pc_out", fq_b.pc_out, pb);
         chk("t5_pc_next", fq_b.pc_next, pb + 32'd4);
         chk("t5_inst", fq_b.inst, mem_word(pb));
         @(negedge clk);
      end
      chk("t5_pc_next_wrap", pb, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
